// File: rtl/rate_counter_hex.sv
// Rate-divided loadable up/down counter with active-low seven-segment hex outputs.
// A free-running divider paces the count steps at one of four switch-selected rates.
module rate_counter_hex #(
  parameter int CLK_FREQ = 50000000,
  parameter int DIGITS   = 2
) (
  input  logic                  CLOCK_50,
  input  logic                  resetn,
  input  logic                  enable,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic [1:0]            rate_sel,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int W     = 4 * DIGITS;
  localparam int DIV_W = $clog2(4 * CLK_FREQ);

  localparam logic [DIV_W-1:0] LAST_1HZ   = DIV_W'(CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] LAST_HALF  = DIV_W'(2 * CLK_FREQ - 1);
  localparam logic [DIV_W-1:0] LAST_QUART = DIV_W'(4 * CLK_FREQ - 1);

  logic [W-1:0]     count_q, count_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick_q, tick_d;
  logic [1:0]       rate_q, rate_d;
  logic [DIV_W-1:0] last_div;

  always_comb begin
    last_div = '0;
    case (rate_q)
      2'b00:   last_div = '0;
      2'b01:   last_div = LAST_1HZ;
      2'b10:   last_div = LAST_HALF;
      default: last_div = LAST_QUART;
    endcase
  end

  // Load beats a rate change, which beats normal counting; rate_q always tracks rate_sel.
  always_comb begin
    count_d = count_q;
    div_d   = div_q;
    tick_d  = 1'b0;
    rate_d  = rate_sel;
    if (load) begin
      count_d = load_value;
      div_d   = '0;
    end else if (rate_sel != rate_q) begin
      div_d = '0;
    end else if (enable) begin
      if (div_q == last_div) begin
        div_d   = '0;
        tick_d  = 1'b1;
        count_d = up ? count_q + W'(1) : count_q - W'(1);
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      count_q <= '0;
      div_q   <= '0;
      tick_q  <= 1'b0;
      rate_q  <= 2'b00;
    end else begin
      count_q <= count_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      rate_q  <= rate_d;
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign hex[7*i +: 7] = seg7(count_q[4*i +: 4]);
  end

  assign count = count_q;
  assign tick  = tick_q;

endmodule

// File: tb/tb_rate_counter_hex.sv
// Scoreboard bench for rate_counter_hex: a period/phase reference model predicts each
// cycle's count and tick, and a monitor compares them against the DUT after every edge.
module tb_rate_counter_hex;

  localparam int CLK_FREQ = 4;
  localparam int DIGITS   = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        enable;
  logic        up;
  logic        load;
  logic [7:0]  load_value;
  logic [1:0]  rate_sel;
  logic [7:0]  count;
  logic        tick;
  logic [13:0] hex;

  typedef struct {
    logic [7:0] cnt;
    logic       tck;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;

  int         m_count;
  int         m_phase;
  logic [1:0] m_rate;

  rate_counter_hex #(.CLK_FREQ(CLK_FREQ), .DIGITS(DIGITS)) dut (
    .CLOCK_50  (clk),
    .resetn    (resetn),
    .enable    (enable),
    .up        (up),
    .load      (load),
    .load_value(load_value),
    .rate_sel  (rate_sel),
    .count     (count),
    .tick      (tick),
    .hex       (hex)
  );

  always #5 clk = ~clk;

  function automatic int periodOf(input logic [1:0] r);
    if (r == 2'b00) return 1;
    return CLK_FREQ << (r - 1);
  endfunction

  function automatic logic [6:0] segOf(input logic [3:0] n);
    logic [6:0] tab [16];
    tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
            7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
            7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    return tab[n];
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle's inputs at the falling edge and predict the state after the next rising edge.
  task automatic applyStimulus(input logic en, input logic u, input logic ld,
                               input logic [7:0] lv, input logic [1:0] rs);
    exp_t e;
    @(negedge clk);
    enable = en; up = u; load = ld; load_value = lv; rate_sel = rs;
    e.tck = 1'b0;
    if (ld) begin
      m_count = lv;
      m_phase = 0;
    end else if (rs != m_rate) begin
      m_phase = 0;
    end else if (en) begin
      m_phase++;
      if (m_phase == periodOf(m_rate)) begin
        m_phase = 0;
        m_count = u ? (m_count + 1) % 256 : (m_count + 255) % 256;
        e.tck   = 1'b1;
      end
    end
    m_rate = rs;
    e.cnt  = m_count[7:0];
    sb.push_back(e);
  endtask

  // Pulse reset between edges, check the cleared outputs before any edge, release after an edge.
  task automatic resetPulse();
    @(negedge clk);
    #2 resetn = 1'b0;
    #1;
    checkOutput("reset count", {24'd0, count}, 32'd0);
    checkOutput("reset tick", {31'd0, tick}, 32'd0);
    checkOutput("reset hex", {18'd0, hex}, {18'd0, 14'b1000000_1000000});
    m_count = 0; m_phase = 0; m_rate = 2'b00;
    enable = 1'b0; load = 1'b0; rate_sel = 2'b00;
    @(posedge clk);
    #2 resetn = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput("count", {24'd0, count}, {24'd0, e.cnt});
        checkOutput("tick", {31'd0, tick}, {31'd0, e.tck});
        checkOutput("hex", {18'd0, hex}, {18'd0, segOf(e.cnt[7:4]), segOf(e.cnt[3:0])});
      end
    end
  end

  initial begin : stimulus
    logic [1:0] cur_rs;
    resetn = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_value = 8'h00; rate_sel = 2'b00;
    m_count = 0; m_phase = 0; m_rate = 2'b00;
    #3;
    checkOutput("power-on count", {24'd0, count}, 32'd0);
    checkOutput("power-on hex", {18'd0, hex}, {18'd0, 14'b1000000_1000000});
    @(posedge clk);
    #2 resetn = 1'b1;

    // Rate 01 counting up: first step on the 4th edge after the rate change settles.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 12; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);

    // Down wrap from zero at full rate.
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00, 2'b00);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'b00);

    // Up wrap from FF at full rate.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hFE, 2'b00);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b00);

    // Load mid-period restarts the divider.
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    applyStimulus(1'b1, 1'b1, 1'b1, 8'hA5, 2'b01);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);

    // Rate change mid-period, then a 16-edge period.
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b11);

    // Load and rate change together, then enable gating mid-period with a direction flip.
    applyStimulus(1'b1, 1'b1, 1'b1, 8'h10, 2'b01);
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 2'b01);
    for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 2'b01);

    // Reset three edges into a period.
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);
    resetPulse();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h00, 2'b01);

    // Randomized traffic with occasional loads and rate changes.
    cur_rs = 2'b01;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 3) cur_rs = 2'($urandom_range(0, 3));
      applyStimulus(($urandom_range(0, 99) < 80), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 4), 8'($urandom_range(0, 255)), cur_rs);
    end

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
